instr_fetch_sequencer: RTL and testbench
========================================

Name: instr_fetch_sequencer

Overview:
- Program sequencer directly upstream of the instruction decoder.
- Fetches instruction words from a synchronous-read program memory and splits each word into opcode and operand.
- Presents one registered instruction per slot to the decoder, then consumes the decoder's f_wait back to stall for an operand-specified number of cycles.
- Runs from address 0 to a programmable last address, then reports done.

Parameters:
- OPCODE_WIDTH, 3, opcode field width; must match the decoder's width.
- OPERAND_WIDTH, 8, operand field width; the WAIT stall count is taken from this field.
- INSTR_WIDTH, OPCODE_WIDTH+OPERAND_WIDTH, instruction word width; opcode occupies the MSBs.
- PC_WIDTH, 6, program counter width (64-word program space).

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  one-cycle request to start execution at PC 0; honoured only in IDLE or DONE.
- prog_last  in  PC_WIDTH  address of the final instruction; sampled when start is accepted.
- imem_rd_en  out  1  program memory read strobe.
- imem_addr  out  PC_WIDTH  program memory read address.
- imem_rdata  in  INSTR_WIDTH  read data; valid in the cycle after imem_rd_en.
- opcode  out  OPCODE_WIDTH  registered opcode, driven to the decoder.
- operand  out  OPERAND_WIDTH  registered operand, driven to the datapath.
- instr_valid  out  1  high for exactly one cycle per issued instruction.
- f_wait  in  1  decoder WAIT flag; combinational from opcode, sampled only while instr_valid=1.
- busy  out  1  high in any state other than IDLE and DONE.
- done  out  1  high in DONE; held until the next accepted start.

Behaviour:
- Reset values: state=IDLE, pc=0, ir=0, wait counter=0; all outputs 0 (opcode, operand, imem_addr, imem_rd_en, instr_valid, busy, done).
- States:
  - IDLE
  - FETCH: imem_rd_en=1, imem_addr=pc.
  - LOAD: ir <= imem_rdata.
  - EXEC: instr_valid=1.
  - WAIT
  - DONE
- Transitions:
  - IDLE/DONE + start: pc<=0, latch prog_last, clear done, go to FETCH.
  - FETCH goes to LOAD. LOAD goes to EXEC.
  - EXEC with f_wait=1 and operand!=0: load counter with operand, go to WAIT.
  - EXEC with f_wait=0, or with operand==0: go to ADV.
  - WAIT: decrement each cycle; when counter==1, go to ADV. The stall is exactly operand cycles with instr_valid=0.
  - ADV (an action on the leaving edge, not a state): if pc==prog_last_latched, go to DONE; else pc<=pc+1 and go to FETCH.
- Latency: start-to-first instr_valid = 3 cycles (FETCH, LOAD, EXEC). Non-WAIT instructions issue every 3 cycles.
- opcode and operand hold the last loaded value outside EXEC. The decoder sees stable inputs throughout the slot.
- start while busy is ignored. A change of prog_last after start has no effect.
- pc never exceeds prog_last.
- When prog_last = 2^PC_WIDTH-1, pc does not wrap; DONE is reached first.
- imem_rd_en is never high outside FETCH.
- rst_n low mid-WAIT or mid-FETCH: immediate return to reset values; the in-flight read data is discarded.
- f_wait seen outside EXEC is ignored.

Optional Feature:
- Macro: SEQ_LOOP_EN.
- Defined:
  - Adds input loop_mode (1) and output loop_count (8).
  - At ADV with pc==prog_last and loop_mode=1: pc<=0, loop_count increments (wraps at 255), go to FETCH. done is not asserted.
  - loop_mode=0 in that case behaves as without the feature.
  - start clears loop_count.
- Undefined: ports absent; behaviour exactly as above.

Decomposition:
- Shared package seq_pkg holds:
  - the state enum (IDLE, FETCH, LOAD, EXEC, WAIT, DONE);
  - the field-slice constants OPCODE_MSB/LSB and OPERAND_MSB/LSB.
- Opcode values remain in the shared opcodes include. The sequencer never decodes opcodes itself; it relies only on f_wait.
- One natural sub-module: wait_counter (load, decrement, terminal-count flag, OPERAND_WIDTH wide).

Test Plan:
- Reset then start, prog_last=2, memory {MOV|0x05, MAC|0x00, SETB|0x11}:
  - instr_valid pulses at cycles 3, 6, 9 with matching opcode/operand;
  - done rises at cycle 10;
  - busy falls with it.
- WAIT|0x04 at address 0, MOV at address 1, decoder in loop: gap between the two instr_valid pulses = 3+4 = 7 cycles; imem_rd_en low throughout the 4 WAIT cycles.
- WAIT|0x00: no stall; next instr_valid 3 cycles later.
- start pulsed during EXEC and WAIT: ignored, sequence unchanged. start in DONE: restarts at pc=0, done clears next cycle.
- prog_last=63, all MOV: 64 instr_valid pulses, imem_addr 0..63, no wrap, then done.
- rst_n dropped mid-WAIT (counter=3): all outputs 0 asynchronously; after release, state=IDLE and no instr_valid until start. With SEQ_LOOP_EN and loop_mode=1, prog_last=1: loop_count increments every 6 cycles and done stays 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   seq_state_e : sequencer FSM states
//   OPCODE_MSB/LSB, OPERAND_MSB/LSB : field split of an instruction word.
//     The opcode occupies the MSBs and the operand the LSBs.
// Optional feature macro used by the sequencer: SEQ_LOOP_EN.
package seq_pkg;

  localparam int SEQ_OPCODE_WIDTH  = 3;
  localparam int SEQ_OPERAND_WIDTH = 8;
  localparam int SEQ_INSTR_WIDTH   = SEQ_OPCODE_WIDTH + SEQ_OPERAND_WIDTH;
  localparam int SEQ_PC_WIDTH      = 6;

  localparam int OPCODE_MSB  = SEQ_INSTR_WIDTH - 1;
  localparam int OPCODE_LSB  = SEQ_OPERAND_WIDTH;
  localparam int OPERAND_MSB = SEQ_OPERAND_WIDTH - 1;
  localparam int OPERAND_LSB = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    EXEC  = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } seq_state_e;

endpackage

// File: rtl/instr_fetch_sequencer_wait_counter.sv
// wait_counter: stall counter for the WAIT instruction.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : load load_value (has priority over dec)
//   load_value  : stall length in cycles
//   dec         : decrement by one (saturates at zero)
//   tc          : terminal count, high while the count equals 1
module wait_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             tc
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  // Terminal count at 1 so the last stall cycle is the one that leaves WAIT.
  assign tc = (count_reg == WIDTH'(1));

endmodule

// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: program sequencer feeding the instruction decoder.
// Fetches words from a synchronous-read program memory (address 0 to the
// latched last address), splits them into opcode/operand and issues one
// instruction per FETCH/LOAD/EXEC slot. A decoder WAIT flag (f_wait) during
// EXEC stalls the sequence for operand cycles.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   start, prog_last : start request and last program address
//   imem_rd_en/addr  : program memory read strobe and address
//   imem_rdata       : read data, valid the cycle after imem_rd_en
//   opcode, operand  : registered instruction fields
//   instr_valid      : one-cycle pulse per issued instruction
//   f_wait           : decoder WAIT flag, looked at only in EXEC
//   busy, done       : activity and completion status
//   loop_mode, loop_count : only when SEQ_LOOP_EN is defined; the program
//                      restarts at 0 instead of finishing and counts loops.
module instr_fetch_sequencer
  import seq_pkg::*;
#(
  parameter int OPCODE_WIDTH  = SEQ_OPCODE_WIDTH,
  parameter int OPERAND_WIDTH = SEQ_OPERAND_WIDTH,
  parameter int INSTR_WIDTH   = OPCODE_WIDTH + OPERAND_WIDTH,
  parameter int PC_WIDTH      = SEQ_PC_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [PC_WIDTH-1:0]      prog_last,
  output logic                     imem_rd_en,
  output logic [PC_WIDTH-1:0]      imem_addr,
  input  logic [INSTR_WIDTH-1:0]   imem_rdata,
  output logic [OPCODE_WIDTH-1:0]  opcode,
  output logic [OPERAND_WIDTH-1:0] operand,
  output logic                     instr_valid,
  input  logic                     f_wait,
  output logic                     busy,
`ifdef SEQ_LOOP_EN
  input  logic                     loop_mode,
  output logic [7:0]               loop_count,
`endif
  output logic                     done
);

  seq_state_e             state_reg, state_next;
  logic [PC_WIDTH-1:0]    pc_reg, pc_next;
  logic [PC_WIDTH-1:0]    last_reg, last_next;
  logic [INSTR_WIDTH-1:0] ir_reg, ir_next;
  logic                   cnt_load, cnt_dec, cnt_tc;
  logic                   adv;
`ifdef SEQ_LOOP_EN
  logic [7:0]             loop_count_reg, loop_count_next;
`endif

  wait_counter #(.WIDTH(OPERAND_WIDTH)) u_wait_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (cnt_load),
    .load_value (operand),
    .dec        (cnt_dec),
    .tc         (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      last_reg  <= '0;
      ir_reg    <= '0;
`ifdef SEQ_LOOP_EN
      loop_count_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      last_reg  <= last_next;
      ir_reg    <= ir_next;
`ifdef SEQ_LOOP_EN
      loop_count_reg <= loop_count_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    last_next  = last_reg;
    ir_next    = ir_reg;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    adv        = 1'b0;
`ifdef SEQ_LOOP_EN
    loop_count_next = loop_count_reg;
`endif

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          pc_next    = '0;
          last_next  = prog_last;
          state_next = FETCH;
`ifdef SEQ_LOOP_EN
          loop_count_next = '0;
`endif
        end
      end
      FETCH: state_next = LOAD;
      LOAD: begin
        ir_next    = imem_rdata;
        state_next = EXEC;
      end
      EXEC: begin
        // A zero-length WAIT behaves like any other instruction.
        if (f_wait && (operand != '0)) begin
          cnt_load   = 1'b1;
          state_next = WAIT;
        end else begin
          adv = 1'b1;
        end
      end
      WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_tc) adv = 1'b1;
      end
      default: state_next = IDLE;
    endcase

    // Advance step on the edge leaving EXEC or WAIT. Comparing against the
    // latched last address before incrementing keeps pc from ever wrapping.
    if (adv) begin
      if (pc_reg == last_reg) begin
`ifdef SEQ_LOOP_EN
        if (loop_mode) begin
          pc_next         = '0;
          loop_count_next = loop_count_reg + 8'd1;
          state_next      = FETCH;
        end else begin
          state_next = DONE;
        end
`else
        state_next = DONE;
`endif
      end else begin
        pc_next    = pc_reg + 1'b1;
        state_next = FETCH;
      end
    end
  end

  assign imem_rd_en  = (state_reg == FETCH);
  assign imem_addr   = pc_reg;
  assign opcode      = ir_reg[OPCODE_MSB:OPCODE_LSB];
  assign operand     = ir_reg[OPERAND_MSB:OPERAND_LSB];
  assign instr_valid = (state_reg == EXEC);
  assign busy        = (state_reg != IDLE) && (state_reg != DONE);
  assign done        = (state_reg == DONE);
`ifdef SEQ_LOOP_EN
  assign loop_count  = loop_count_reg;
`endif

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Testbench for instr_fetch_sequencer: directed programs, expected issued
// instructions (opcode, operand, cycle) queued by the stimulus and checked
// by an independent monitor on every instr_valid pulse.
module tb_instr_fetch_sequencer;

  localparam logic [2:0] OP_MOV  = 3'd1;
  localparam logic [2:0] OP_MAC  = 3'd2;
  localparam logic [2:0] OP_SETB = 3'd3;
  localparam logic [2:0] OP_WAIT = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  prog_last = '0;
  logic        imem_rd_en;
  logic [5:0]  imem_addr;
  logic [10:0] imem_rdata = '0;
  logic [2:0]  opcode;
  logic [7:0]  operand;
  logic        instr_valid;
  logic        f_wait;
  logic        busy;
  logic        done;
`ifdef SEQ_LOOP_EN
  logic        loop_mode = 1'b0;
  logic [7:0]  loop_count;
`endif

  logic [10:0] mem [64];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] opnd;
    int         at;
  } exp_t;
  exp_t exp_q[$];

  instr_fetch_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .prog_last  (prog_last),
    .imem_rd_en (imem_rd_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .opcode     (opcode),
    .operand    (operand),
    .instr_valid(instr_valid),
    .f_wait     (f_wait),
    .busy       (busy),
`ifdef SEQ_LOOP_EN
    .loop_mode  (loop_mode),
    .loop_count (loop_count),
`endif
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Synchronous-read program memory and a decoder that flags WAIT.
  always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];
  assign f_wait = (opcode == OP_WAIT);

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every issued instruction must match the head of the queue.
  always @(negedge clk) begin
    if (instr_valid) begin
      $display("cycle %0d: issue opcode=%0h operand=%0h", cyc, opcode, operand);
      if (exp_q.size() == 0) begin
        check("unexpected_instr_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("opcode", int'(opcode), int'(e.op));
        check("operand", int'(operand), int'(e.opnd));
        check("issue_cycle", cyc, e.at);
      end
    end
  end

  task automatic goto_cycle(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_start(input logic [5:0] last, output int s);
    @(negedge clk);
    prog_last = last;
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_instr(input logic [2:0] op, input logic [7:0] v, input int at);
    exp_t e;
    e.op = op; e.opnd = v; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_imem_rd_en"}, int'(imem_rd_en), 0);
    check({tag, "_imem_addr"}, int'(imem_addr), 0);
    check({tag, "_opcode"}, int'(opcode), 0);
    check({tag, "_operand"}, int'(operand), 0);
    check({tag, "_instr_valid"}, int'(instr_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    for (int i = 0; i < 64; i++) mem[i] = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("idle");

    // Three-instruction program; prog_last changed after start must not matter.
    mem[0] = {OP_MOV, 8'h05};
    mem[1] = {OP_MAC, 8'h00};
    mem[2] = {OP_SETB, 8'h11};
    do_start(6'd2, s);
    prog_last = 6'd0;
    expect_instr(OP_MOV, 8'h05, s + 3);
    expect_instr(OP_MAC, 8'h00, s + 6);
    expect_instr(OP_SETB, 8'h11, s + 9);
    goto_cycle(s + 9);
    check("a_busy_before_done", int'(busy), 1);
    check("a_done_before_done", int'(done), 0);
    goto_cycle(s + 10);
    check("a_done", int'(done), 1);
    check("a_busy_at_done", int'(busy), 0);

    // WAIT 4 then MOV; start pulses during EXEC and WAIT are ignored.
    mem[0] = {OP_WAIT, 8'h04};
    mem[1] = {OP_MOV, 8'h22};
    do_start(6'd1, s);
    expect_instr(OP_WAIT, 8'h04, s + 3);
    expect_instr(OP_MOV, 8'h22, s + 10);
    goto_cycle(s + 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 4; k <= 7; k++) begin
      goto_cycle(s + k);
      check("b_rd_en_in_wait", int'(imem_rd_en), 0);
      check("b_busy_in_wait", int'(busy), 1);
      start = (k == 5);
    end
    goto_cycle(s + 8);
    start = 1'b0;
    check("b_rd_en_after_wait", int'(imem_rd_en), 1);
    goto_cycle(s + 11);
    check("b_done", int'(done), 1);

    // Zero-length WAIT: no stall.
    mem[0] = {OP_WAIT, 8'h00};
    mem[1] = {OP_MOV, 8'h33};
    do_start(6'd1, s);
    expect_instr(OP_WAIT, 8'h00, s + 3);
    expect_instr(OP_MOV, 8'h33, s + 6);
    goto_cycle(s + 7);
    check("c_done", int'(done), 1);

    // Restart from DONE.
    do_start(6'd1, s);
    check("r_done_cleared", int'(done), 0);
    check("r_busy", int'(busy), 1);
    check("r_fetch_addr", int'(imem_addr), 0);
    expect_instr(OP_WAIT, 8'h00, s + 3);
    expect_instr(OP_MOV, 8'h33, s + 6);
    goto_cycle(s + 7);
    check("r_done", int'(done), 1);

    // Full 64-word program: no wrap, done after the last address.
    for (int i = 0; i < 64; i++) mem[i] = {OP_MOV, 8'(i)};
    do_start(6'd63, s);
    for (int i = 0; i < 64; i++) expect_instr(OP_MOV, 8'(i), s + 3 + 3 * i);
    goto_cycle(s + 192);
    check("f_last_addr", int'(imem_addr), 63);
    check("f_done_before", int'(done), 0);
    goto_cycle(s + 193);
    check("f_done", int'(done), 1);
    check("f_addr_no_wrap", int'(imem_addr), 63);

    // Reset asserted mid-WAIT (counter at 3).
    mem[0] = {OP_WAIT, 8'h05};
    do_start(6'd0, s);
    expect_instr(OP_WAIT, 8'h05, s + 3);
    goto_cycle(s + 6);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid_wait");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_done", int'(done), 0);

`ifdef SEQ_LOOP_EN
    mem[0] = {OP_MOV, 8'h01};
    mem[1] = {OP_MOV, 8'h02};
    loop_mode = 1'b1;
    do_start(6'd1, s);
    for (int i = 0; i < 3; i++) begin
      expect_instr(OP_MOV, 8'h01, s + 3 + 6 * i);
      expect_instr(OP_MOV, 8'h02, s + 6 + 6 * i);
    end
    goto_cycle(s + 7);
    check("l_count_1", int'(loop_count), 1);
    check("l_done_low", int'(done), 0);
    goto_cycle(s + 13);
    check("l_count_2", int'(loop_count), 2);
    check("l_done_low2", int'(done), 0);
    loop_mode = 1'b0;
    goto_cycle(s + 19);
    check("l_done", int'(done), 1);
    check("l_count_held", int'(loop_count), 2);
`endif

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
